// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues one fetch per cycle to a 1-cycle instruction memory
// and buffers returned {PC, instruction} pairs in a small FIFO feeding the IF/ID register.
module if_prefetch_queue #(
  parameter int unsigned      XLEN     = 64,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  PC_RESET = {XLEN{1'b0}},
  parameter logic [31:0]      NOP      = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [31:0]            imem_data,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   stall,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            ready_q;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic            issue_s;
  logic            enq_s;
  logic            deq_s;
  logic            head_valid_s;
  logic [CW-1:0]   occupancy_s;

  // Handshake decisions; the in-flight word is counted so the queue can never overflow.
  always_comb begin
    head_valid_s = (count_q != {CW{1'b0}});
    occupancy_s  = count_q + {{(CW-1){1'b0}}, inflight_q};
    issue_s      = ready_q && !redirect && (occupancy_s < DEPTH_C);
    enq_s        = inflight_q && !redirect;
    deq_s        = head_valid_s && !stall && !redirect;
  end

  // Next-state for fetch PC, in-flight tracking, pointers and occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue_s;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = {AW{1'b0}};
      wr_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (issue_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
        req_pc_d   = fetch_pc_q;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end

      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; ready_q keeps imem_req low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= PC_RESET;
      req_pc_q   <= {XLEN{1'b0}};
      inflight_q <= 1'b0;
      ready_q    <= 1'b0;
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      ready_q    <= 1'b1;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage, written with the response that returns one cycle after its request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= {XLEN{1'b0}};
        instr_mem_q[i] <= NOP;
      end
    end else if (enq_s) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_data;
    end else begin
      pc_mem_q[wr_ptr_q]    <= pc_mem_q[wr_ptr_q];
      instr_mem_q[wr_ptr_q] <= instr_mem_q[wr_ptr_q];
    end
  end

  // Head of queue presented directly; idle outputs are forced to a bubble.
  always_comb begin
    imem_req  = issue_s;
    imem_addr = fetch_pc_q;
    out_valid = head_valid_s;
    count     = count_q;
    if (head_valid_s) begin
      out_pc    = pc_mem_q[rd_ptr_q];
      out_instr = instr_mem_q[rd_ptr_q];
    end else begin
      out_pc    = {XLEN{1'b0}};
      out_instr = NOP;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: startup, stall back-pressure, redirect flush and PC wrap.
module tb_if_prefetch_queue;

  localparam logic [63:0] WRAP_BASE = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [31:0] NOP_W     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        stall;

  logic        imem_req, w_imem_req;
  logic [63:0] imem_addr, w_imem_addr;
  logic [31:0] imem_data, w_imem_data;
  logic        out_valid, w_out_valid;
  logic [63:0] out_pc, w_out_pc;
  logic [31:0] out_instr, w_out_instr;
  logic [2:0]  count, w_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_prefetch_queue dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .count(count)
  );

  if_prefetch_queue #(.PC_RESET(WRAP_BASE)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_data(w_imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .out_valid(w_out_valid), .out_pc(w_out_pc),
    .out_instr(w_out_instr), .count(w_count)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // 1-cycle instruction memory: word for the address presented this cycle appears next cycle.
  always @(posedge clk) begin
    imem_data   <= mem_word(imem_addr);
    w_imem_data <= mem_word(w_imem_addr);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, " req"},   64'(imem_req), 64'd0);
    check_val({tag, " addr"},  imem_addr, 64'd0);
    check_val({tag, " valid"}, 64'(out_valid), 64'd0);
    check_val({tag, " pc"},    out_pc, 64'd0);
    check_val({tag, " instr"}, 64'(out_instr), 64'(NOP_W));
    check_val({tag, " count"}, 64'(count), 64'd0);
    check_val({tag, " waddr"}, w_imem_addr, WRAP_BASE);
    check_val({tag, " wreq"},  64'(w_imem_req), 64'd0);
  endtask

  // Pulse reset for a cycle and release it at a falling edge.
  task automatic do_reset(input logic st);
    tick();
    reset = 1'b0;
    redirect = 1'b0;
    stall = st;
    tick();
    reset = 1'b1;
  endtask

  // Fetch addresses and delivered PCs for the first cycles after release, both instances.
  task automatic startup_seq(input string tag);
    tick();
    check_val({tag, " n1 req"},   64'(imem_req), 64'd1);
    check_val({tag, " n1 addr"},  imem_addr, 64'd0);
    check_val({tag, " n1 waddr"}, w_imem_addr, WRAP_BASE);
    tick();
    check_val({tag, " n2 addr"},  imem_addr, 64'd4);
    check_val({tag, " n2 valid"}, 64'(out_valid), 64'd0);
    check_val({tag, " n2 waddr"}, w_imem_addr, WRAP_BASE + 64'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val({tag, " stream valid"}, 64'(out_valid), 64'd1);
      check_val({tag, " stream pc"},    out_pc, 64'(4 * k));
      check_val({tag, " stream instr"}, 64'(out_instr), 64'(mem_word(64'(4 * k))));
      check_val({tag, " stream count"}, 64'(count), 64'd1);
      check_val({tag, " stream addr"},  imem_addr, 64'(8 + 4 * k));
      check_val({tag, " wrap addr"},    w_imem_addr, WRAP_BASE + 64'(8 + 4 * k));
      check_val({tag, " wrap pc"},      w_out_pc, WRAP_BASE + 64'(4 * k));
    end
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 64'd0;
    repeat (2) tick();
    check_reset_state("por");
    reset = 1'b1;
    startup_seq("boot");

    // Reset asserted mid-run takes effect immediately.
    tick();
    reset = 1'b0;
    #1;
    check_reset_state("midrun");
    tick();
    reset = 1'b1;
    startup_seq("restart");

    // Stall back-pressure fills the queue, then drains without gaps.
    do_reset(1'b1);
    repeat (5) tick();
    check_val("stall n5 count", 64'(count), 64'd3);
    check_val("stall n5 req",   64'(imem_req), 64'd0);
    repeat (5) tick();
    check_val("stall full count", 64'(count), 64'd4);
    check_val("stall full req",   64'(imem_req), 64'd0);
    check_val("stall head pc",    out_pc, 64'd0);
    check_val("stall head valid", 64'(out_valid), 64'd1);
    stall = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_val("drain valid", 64'(out_valid), 64'd1);
      check_val("drain pc",    out_pc, 64'(4 * i));
    end

    // Reserved-full queue: dequeue and response on the same edge keep occupancy.
    do_reset(1'b1);
    repeat (5) tick();
    check_val("full n5 count", 64'(count), 64'd3);
    stall = 1'b0;
    tick();
    check_val("full swap count", 64'(count), 64'd3);
    check_val("full swap pc",    out_pc, 64'd4);
    tick();
    check_val("full n7 pc", out_pc, 64'd8);
    tick();
    check_val("full n8 pc", out_pc, 64'd12);
    tick();
    check_val("full n9 pc", out_pc, 64'd16);

    // Redirect with three entries queued and one in flight.
    do_reset(1'b1);
    repeat (5) tick();
    redirect = 1'b1;
    redirect_pc = 64'h100;
    #1;
    check_val("redir req",       64'(imem_req), 64'd0);
    check_val("redir old valid", 64'(out_valid), 64'd1);
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    #1;
    check_val("redir count", 64'(count), 64'd0);
    check_val("redir valid", 64'(out_valid), 64'd0);
    check_val("redir instr", 64'(out_instr), 64'(NOP_W));
    check_val("redir req2",  64'(imem_req), 64'd1);
    check_val("redir addr",  imem_addr, 64'h100);
    tick();
    check_val("redir n7 valid", 64'(out_valid), 64'd0);
    check_val("redir n7 addr",  imem_addr, 64'h104);
    tick();
    check_val("redir first valid", 64'(out_valid), 64'd1);
    check_val("redir first pc",    out_pc, 64'h100);
    check_val("redir first instr", 64'(out_instr), 64'(mem_word(64'h100)));
    tick();
    check_val("redir second pc", out_pc, 64'h104);

    // Back-to-back redirects: the later target wins.
    redirect = 1'b1;
    redirect_pc = 64'h40;
    tick();
    redirect_pc = 64'h80;
    #1;
    check_val("b2b valid", 64'(out_valid), 64'd0);
    check_val("b2b req",   64'(imem_req), 64'd0);
    tick();
    redirect = 1'b0;
    #1;
    check_val("b2b addr",  imem_addr, 64'h80);
    check_val("b2b req2",  64'(imem_req), 64'd1);
    check_val("b2b valid2", 64'(out_valid), 64'd0);
    tick();
    check_val("b2b valid3", 64'(out_valid), 64'd0);
    tick();
    check_val("b2b first valid", 64'(out_valid), 64'd1);
    check_val("b2b first pc",    out_pc, 64'h80);
    tick();
    check_val("b2b second pc", out_pc, 64'h84);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
